// File: rtl/buffer_m1_sequencer.sv
// Mode-1 broadcast sequencer: streams a strided read run into the PE array
// and writes the results back through a fixed-latency strobe delay line.
module buffer_m1_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_stride,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W:0]   len,
  input  logic              stall,
  output logic              m1_r_en,
  output logic [ADDR_W-1:0] m1_r_addr,
  output logic              m1_w_en,
  output logic [ADDR_W-1:0] m1_w_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic [LAT-1:0]    dl;
  logic [LAT-1:0]    dl_nxt;
  logic              w_next;
  logic              issue;
  logic [ADDR_W-1:0] iaddr;

  // dl_nxt[LAT-1] is the write strobe that will be visible next cycle,
  // so the write address can be registered alongside it.
  if (LAT == 1) begin : g_lat1
    assign dl_nxt = m1_r_en;
  end else begin : g_latn
    assign dl_nxt = {dl[LAT-2:0], m1_r_en};
  end

  assign w_next  = dl_nxt[LAT-1];
  assign m1_w_en = dl[LAT-1];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    issue = 1'b0;
    iaddr = rd_ptr;
    unique case (state)
      IDLE: begin
        issue = start && (len != '0) && !stall;
        iaddr = rd_base;
      end
      RUN:     issue = !stall && (rd_cnt < len_q);
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      stride_q  <= '0;
      wr_ptr    <= '0;
      len_q     <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      dl        <= '0;
      m1_r_en   <= 1'b0;
      m1_r_addr <= '0;
      m1_w_addr <= '0;
    end else begin
      dl      <= dl_nxt;
      m1_r_en <= issue;
      if (issue) m1_r_addr <= iaddr;
      if (w_next) begin
        m1_w_addr <= wr_ptr;
        wr_ptr    <= wr_ptr + ADDR_ONE;
      end
      if (m1_w_en) wr_cnt <= wr_cnt + CNT_ONE;

      unique case (state)
        IDLE: begin
          if (start) begin
            stride_q <= rd_stride;
            len_q    <= len;
            wr_ptr   <= wr_base;
            wr_cnt   <= '0;
            rd_cnt   <= issue ? CNT_ONE : '0;
            rd_ptr   <= issue ? rd_base + rd_stride : rd_base;
            if (len == '0)
              state <= DONE;
            else if (issue && len == CNT_ONE)
              state <= DRAIN;
            else
              state <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            rd_ptr <= rd_ptr + stride_q;
            rd_cnt <= rd_cnt + CNT_ONE;
            if (rd_cnt + CNT_ONE == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (m1_w_en && (wr_cnt + CNT_ONE == len_q)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_m1_sequencer.sv
// Directed bench for buffer_m1_sequencer: per-cycle vector table plus
// hand-written address-wrap, empty, full-range, reset and re-start sequences.
module tb_buffer_m1_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [9:0]  rd_base, rd_stride, wr_base;
  logic [10:0] len;
  logic        m1_r_en, m1_w_en, busy, done;
  logic [9:0]  m1_r_addr, m1_w_addr;

  buffer_m1_sequencer #(.ADDR_W(10), .LAT(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_base(rd_base), .rd_stride(rd_stride), .wr_base(wr_base),
    .len(len), .stall(stall),
    .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr),
    .m1_w_en(m1_w_en), .m1_w_addr(m1_w_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, st;
    logic       ren;
    logic [9:0] ra;
    logic       wen;
    logic [9:0] wa;
    logic       b, d;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nerr = 0;

  task automatic add(input logic s, st, ren, input logic [9:0] ra,
                     input logic wen, input logic [9:0] wa,
                     input logic b, d);
    vec_t v;
    v.s = s; v.st = st; v.ren = ren; v.ra = ra;
    v.wen = wen; v.wa = wa; v.b = b; v.d = d;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rq[$], wq[$];
    int nd, nr, nw, dcyc, rbad, wbad, lagbad;
    int er, ew;
    logic hist[2048];
    string tg;

    // scenario 1: len=4, no stall
    add(1,0, 0,10'h000, 0,10'h000, 0,0);
    add(0,0, 1,10'h010, 0,10'h000, 1,0);
    add(0,0, 1,10'h011, 0,10'h000, 1,0);
    add(0,0, 1,10'h012, 0,10'h000, 1,0);
    add(0,0, 1,10'h013, 0,10'h000, 1,0);
    add(0,0, 0,10'h013, 0,10'h000, 1,0);
    add(0,0, 0,10'h013, 1,10'h080, 1,0);
    add(0,0, 0,10'h013, 1,10'h081, 1,0);
    add(0,0, 0,10'h013, 1,10'h082, 1,0);
    add(0,0, 0,10'h013, 1,10'h083, 1,0);
    add(0,0, 0,10'h013, 0,10'h083, 1,1);
    add(0,0, 0,10'h013, 0,10'h083, 0,0);
    // scenario 2: stall in relative cycles 2-3
    add(1,0, 0,10'h013, 0,10'h083, 0,0);
    add(0,0, 1,10'h010, 0,10'h083, 1,0);
    add(0,1, 1,10'h011, 0,10'h083, 1,0);
    add(0,1, 0,10'h011, 0,10'h083, 1,0);
    add(0,0, 0,10'h011, 0,10'h083, 1,0);
    add(0,0, 1,10'h012, 0,10'h083, 1,0);
    add(0,0, 1,10'h013, 1,10'h080, 1,0);
    add(0,0, 0,10'h013, 1,10'h081, 1,0);
    add(0,0, 0,10'h013, 0,10'h081, 1,0);
    add(0,0, 0,10'h013, 0,10'h081, 1,0);
    add(0,0, 0,10'h013, 1,10'h082, 1,0);
    add(0,0, 0,10'h013, 1,10'h083, 1,0);
    add(0,0, 0,10'h013, 0,10'h083, 1,1);
    add(0,0, 0,10'h013, 0,10'h083, 0,0);
    // scenario 3: second start in relative cycle 2 is ignored
    add(1,0, 0,10'h013, 0,10'h083, 0,0);
    add(0,0, 1,10'h010, 0,10'h083, 1,0);
    add(1,0, 1,10'h011, 0,10'h083, 1,0);
    add(0,0, 1,10'h012, 0,10'h083, 1,0);
    add(0,0, 1,10'h013, 0,10'h083, 1,0);
    add(0,0, 0,10'h013, 0,10'h083, 1,0);
    add(0,0, 0,10'h013, 1,10'h080, 1,0);
    add(0,0, 0,10'h013, 1,10'h081, 1,0);
    add(0,0, 0,10'h013, 1,10'h082, 1,0);
    add(0,0, 0,10'h013, 1,10'h083, 1,0);
    add(0,0, 0,10'h013, 0,10'h083, 1,1);
    add(0,0, 0,10'h013, 0,10'h083, 0,0);

    rst = 1; start = 0; stall = 0;
    rd_base = 10'h010; rd_stride = 10'h001;
    wr_base = 10'h080; len = 11'd4;
    tick(); tick();
    rst = 0;

    foreach (tbl[i]) begin
      start = tbl[i].s;
      stall = tbl[i].st;
      tg = $sformatf("row%0d", i);
      chk({tg, ".r_en"},   int'(m1_r_en),   int'(tbl[i].ren));
      chk({tg, ".r_addr"}, int'(m1_r_addr), int'(tbl[i].ra));
      chk({tg, ".w_en"},   int'(m1_w_en),   int'(tbl[i].wen));
      chk({tg, ".w_addr"}, int'(m1_w_addr), int'(tbl[i].wa));
      chk({tg, ".busy"},   int'(busy),      int'(tbl[i].b));
      chk({tg, ".done"},   int'(done),      int'(tbl[i].d));
      tick();
    end
    start = 0; stall = 0;

    // address wrap at the top of the buffer
    rd_base = 10'h3FE; rd_stride = 10'h003; wr_base = 10'h3FF; len = 11'd3;
    start = 1; tick(); start = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (m1_r_en) rq.push_back(int'(m1_r_addr));
      if (m1_w_en) wq.push_back(int'(m1_w_addr));
      if (done) nd++;
      tick();
    end
    chk("wrap.nreads", rq.size(), 3);
    chk("wrap.nwrites", wq.size(), 3);
    chk("wrap.done_pulses", nd, 1);
    if (rq.size() == 3) begin
      chk("wrap.r0", rq[0], 'h3FE);
      chk("wrap.r1", rq[1], 'h001);
      chk("wrap.r2", rq[2], 'h004);
    end
    if (wq.size() == 3) begin
      chk("wrap.w0", wq[0], 'h3FF);
      chk("wrap.w1", wq[1], 'h000);
      chk("wrap.w2", wq[2], 'h001);
    end

    // empty job
    len = 11'd0;
    start = 1; tick(); start = 0;
    chk("len0.busy1", int'(busy), 1);
    chk("len0.done1", int'(done), 1);
    chk("len0.r_en1", int'(m1_r_en), 0);
    tick();
    chk("len0.busy2", int'(busy), 0);
    chk("len0.done2", int'(done), 0);
    nr = 0;
    for (int c = 0; c < 8; c++) begin
      if (m1_r_en || m1_w_en) nr++;
      tick();
    end
    chk("len0.strobes", nr, 0);

    // full-range job
    rd_base = 10'h000; rd_stride = 10'h001; wr_base = 10'h200;
    len = 11'd1024;
    nr = 0; nw = 0; dcyc = -1; rbad = 0; wbad = 0; lagbad = 0;
    er = 0; ew = 'h200;
    for (int c = 0; c < 1045; c++) begin
      start = (c == 0);
      hist[c] = m1_r_en;
      if (m1_r_en) begin
        nr++;
        if (int'(m1_r_addr) != er) rbad++;
        er = (er + 1) % 1024;
      end
      if (m1_w_en) begin
        nw++;
        if (int'(m1_w_addr) != ew) wbad++;
        ew = (ew + 1) % 1024;
      end
      if (c >= 5 && m1_w_en != hist[c-5]) lagbad++;
      if (done && dcyc < 0) dcyc = c;
      tick();
    end
    start = 0;
    chk("full.nreads", nr, 1024);
    chk("full.nwrites", nw, 1024);
    chk("full.raddr_errs", rbad, 0);
    chk("full.waddr_errs", wbad, 0);
    chk("full.lag_errs", lagbad, 0);
    chk("full.done_cycle", dcyc, 1030);

    // reset mid-job, then fresh start at cycle 8
    rd_base = 10'h010; rd_stride = 10'h001; wr_base = 10'h080; len = 11'd4;
    for (int c = 0; c < 22; c++) begin
      start = (c == 0 || c == 8);
      rst   = (c == 3);
      tg = $sformatf("rst.c%0d", c);
      if (c >= 1 && c <= 3) begin
        chk({tg, ".r_en"}, int'(m1_r_en), 1);
        chk({tg, ".r_addr"}, int'(m1_r_addr), 'h010 + c - 1);
      end else if (c >= 4) begin
        chk({tg, ".r_en"}, int'(m1_r_en), int'(c >= 9 && c <= 12));
        chk({tg, ".w_en"}, int'(m1_w_en), int'(c >= 14 && c <= 17));
        chk({tg, ".busy"}, int'(busy), int'(c >= 9 && c <= 18));
        chk({tg, ".done"}, int'(done), int'(c == 18));
        if (c == 4) begin
          chk({tg, ".r_addr"}, int'(m1_r_addr), 0);
          chk({tg, ".w_addr"}, int'(m1_w_addr), 0);
        end
        if (c >= 9 && c <= 12)
          chk({tg, ".r_addr"}, int'(m1_r_addr), 'h010 + c - 9);
        if (c >= 14 && c <= 17)
          chk({tg, ".w_addr"}, int'(m1_w_addr), 'h080 + c - 14);
      end
      tick();
    end
    rst = 0; start = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
